// File: rtl/mips_register_file_pkg.sv
// rtl/mips_register_file_pkg.sv - shared register-file constants
// Also used by the control unit and the writeback mux.
package mips_register_file_pkg;
  localparam int         DATA_WIDTH = 32;
  localparam int         ADDR_WIDTH = 5;
  localparam int         REG_COUNT  = 32;
  localparam logic [4:0] REG_ZERO   = 5'd0;
endpackage

// File: rtl/mips_register_file_reg32_en.sv
// rtl/mips_register_file_reg32_en.sv - register with sync active-low clear and write enable
module reg32_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear wins over enable, so a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - MIPS GPR file, 2 async read ports, 1 clocked write port
// Register 0 has no storage and always reads zero.
module mips_register_file #(
  parameter int DATA_WIDTH = mips_register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mips_register_file_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);
  import mips_register_file_pkg::*;

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] w_q [NUM_REGS];
  logic [NUM_REGS-1:1]   w_we;

  assign w_q[REG_ZERO] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
    assign w_we[i] = reg_write && (write_reg == ADDR_WIDTH'(i));

    reg32_en #(
      .WIDTH(DATA_WIDTH)
    ) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .i_en (w_we[i]),
      .i_d  (write_data),
      .o_q  (w_q[i])
    );
  end

  // No write-to-read bypass: a same-cycle read returns the pre-edge value.
  assign read_data1 = w_q[read_reg1];
  assign read_data2 = w_q[read_reg2];

endmodule

// File: tb/tb_mips_register_file.sv
// tb/tb_mips_register_file.sv - scoreboard bench for mips_register_file
module tb_mips_register_file;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mips_register_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .reg_write (reg_write),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  // Inputs change 1 time unit after a rising edge; the expectation describes
  // the read ports before the next rising edge commits this step's write.
  task automatic step(input logic rn, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                      input logic chk, input logic [31:0] e1, input logic [31:0] e2,
                      input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = rn;
    reg_write  = we;
    write_reg  = wr;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
    if (chk) begin
      e.e1  = e1;
      e.e2  = e2;
      e.tag = tag;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (read_data1 !== e.e1) begin
        failures++;
        $display("FAIL %s rd1 got=%h exp=%h", e.tag, read_data1, e.e1);
      end
      checks++;
      if (read_data2 !== e.e2) begin
        failures++;
        $display("FAIL %s rd2 got=%h exp=%h", e.tag, read_data2, e.e2);
      end
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;

    // Reset and lose a prior write
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0, "init");
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 32'h0, 32'h0, "reset_val");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 32'hDEADBEEF, 32'h0, "pre_reset");
    for (int i = 1; i <= 16; i++)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i), 1'b1, 32'h0, 32'h0, "reset_sweep");

    // Write all, reading each target just before its write commits
    for (int i = 1; i <= 31; i++)
      step(1'b1, 1'b1, 5'(i), 32'hA5A50000 + i, 5'(i), 5'd0, 1'b1, 32'h0, 32'h0, "pre_write");
    for (int i = 1; i <= 31; i++)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i), 1'b1,
           32'hA5A50000 + i, 32'hA5A50000 + (32 - i), "read_pairs");

    // $0 protection
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "zero_wr");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "zero_rd");

    // Enable gating
    step(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b1, 32'hA5A50007, 32'hA5A50007, "en_setup");
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 5'd7, 32'h0BADF00D, 5'd7, 5'd7, 1'b1, 32'h12345678, 32'h12345678, "en_gate");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd6, 1'b1, 32'h12345678, 32'hA5A50006, "en_after");

    // Read during write, no bypass
    step(1'b1, 1'b1, 5'd9, 32'h11111111, 5'd9, 5'd9, 1'b1, 32'hA5A50009, 32'hA5A50009, "rdw_setup");
    step(1'b1, 1'b1, 5'd9, 32'h22222222, 5'd9, 5'd9, 1'b1, 32'h11111111, 32'h11111111, "rdw_before");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 32'h22222222, 32'h22222222, "rdw_after");

    // Back-to-back writes to the same register
    step(1'b1, 1'b1, 5'd4, 32'h00000001, 5'd4, 5'd5, 1'b1, 32'hA5A50004, 32'hA5A50005, "b2b_1");
    step(1'b1, 1'b1, 5'd4, 32'h00000002, 5'd4, 5'd5, 1'b1, 32'h00000001, 32'hA5A50005, "b2b_2");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd31, 1'b1, 32'h00000002, 32'hA5A5001F, "b2b_rd");

    // Reset vs write collision, then write resumes
    step(1'b0, 1'b1, 5'd3, 32'hCAFEBABE, 5'd3, 5'd9, 1'b1, 32'hA5A50003, 32'h22222222, "coll_pre");
    step(1'b1, 1'b1, 5'd3, 32'hCAFEBABE, 5'd3, 5'd9, 1'b1, 32'h0, 32'h0, "coll_reset");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 1'b1, 32'hCAFEBABE, 32'h0, "coll_write");

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
